// File: rtl/mul4_eval_pkg.sv
// Shared types and constants for the mul4 fitness evaluator.
package mul4_eval_pkg;

  localparam int          PROD_W       = 64;
  localparam logic [31:0] LFSR_POLY    = 32'h8020_0003;
  localparam logic [31:0] DEFAULT_SEED = 32'hACE1_2468;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GEN_A,
    S_GEN_B,
    S_MUL,
    S_CMP,
    S_DONE
  } eval_state_t;

  // Operand pair as presented to the candidate: A = {a1,a0}, B = {b1,b0}
  typedef struct packed {
    logic [15:0] a1;
    logic [15:0] a0;
    logic [15:0] b1;
    logic [15:0] b0;
  } operand_t;

  // One step of the right-shifting Galois LFSR
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0);
  endfunction

  // Number of set bits in a product-width word (0..64)
  function automatic logic [6:0] popcount64(input logic [PROD_W-1:0] v);
    logic [6:0] c;
    c = '0;
    for (int i = 0; i < PROD_W; i++) c = c + 7'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/mul32_seq.sv
// 32x32 -> 64 shift-add multiplier, one multiplier bit per step, LSB first.
module mul32_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        step,
  output logic [63:0] prod,
  output logic        last
);

  logic [63:0] mcand_q;
  logic [63:0] acc_q;
  logic [31:0] mplier_q;
  logic [4:0]  cnt_q;

  // Load clears the accumulator; each step conditionally adds the shifted multiplicand
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else if (load) begin
      mcand_q  <= {32'h0, a};
      mplier_q <= b;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (step) begin
      if (mplier_q[0]) acc_q <= acc_q + mcand_q;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 5'd1;
    end
  end

  // last marks the step that retires the 32nd multiplier bit
  assign last = step && (cnt_q == 5'd31);
  assign prod = acc_q;

endmodule

// File: rtl/mul4_fitness_eval.sv
// Drives LFSR operand pairs into a mul4 candidate and scores its products
// against an internal sequential golden multiplier.
module mul4_fitness_eval
  import mul4_eval_pkg::*;
#(
  parameter int unsigned N_VECTORS = 256,
  parameter logic [31:0] SEED      = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [15:0] score,
  output logic [31:0] bit_err,
  output logic [15:0] a1,
  output logic [15:0] a0,
  output logic [15:0] b1,
  output logic [15:0] b0,
  input  logic [15:0] y3,
  input  logic [15:0] y2,
  input  logic [15:0] y1,
  input  logic [15:0] y0
);

  // An all-zero seed would lock the LFSR
  localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [15:0] N_LAST   = 16'(N_VECTORS);

  eval_state_t       state_q, state_d;
  logic [31:0]       lfsr_q;
  operand_t          ops_q;
  logic [15:0]       score_q;
  logic [31:0]       bit_err_q;
  logic [15:0]       vcnt_q;
  logic [15:0]       vcnt_inc;

  logic              run_init, ld_a, ld_b, mul_step, cmp_en, mul_last;
  logic [PROD_W-1:0] golden, diff;
  logic [6:0]        diff_pop;
  logic [32:0]       err_sum;

  // Golden product; B is taken straight from the LFSR on the GEN_B edge
  mul32_seq u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (ld_b),
    .a     ({ops_q.a1, ops_q.a0}),
    .b     (lfsr_q),
    .step  (mul_step),
    .prod  (golden),
    .last  (mul_last)
  );

  assign diff     = golden ^ {y3, y2, y1, y0};
  assign diff_pop = popcount64(diff);
  assign err_sum  = {1'b0, bit_err_q} + 33'(diff_pop);
  assign vcnt_inc = vcnt_q + 16'd1;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_GEN_A;
      S_GEN_A: state_d = S_GEN_B;
      S_GEN_B: state_d = S_MUL;
      S_MUL:   if (mul_last) state_d = S_CMP;
      S_CMP:   state_d = (vcnt_inc == N_LAST) ? S_DONE : S_GEN_A;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State-decoded strobes and status outputs
  always_comb begin
    run_init = (state_q == S_IDLE) && start;
    ld_a     = (state_q == S_GEN_A);
    ld_b     = (state_q == S_GEN_B);
    mul_step = (state_q == S_MUL);
    cmp_en   = (state_q == S_CMP);
    busy     = (state_q != S_IDLE) && (state_q != S_DONE);
    done     = (state_q == S_DONE);
  end

  // LFSR, operand registers and run accumulators
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q    <= SEED_EFF;
      ops_q     <= '0;
      score_q   <= '0;
      bit_err_q <= '0;
      vcnt_q    <= '0;
    end else begin
      if (run_init) begin
        lfsr_q    <= SEED_EFF;
        score_q   <= '0;
        bit_err_q <= '0;
        vcnt_q    <= '0;
      end
      if (ld_a) begin
        {ops_q.a1, ops_q.a0} <= lfsr_q;
        lfsr_q               <= lfsr_step(lfsr_q);
      end
      if (ld_b) begin
        {ops_q.b1, ops_q.b0} <= lfsr_q;
        lfsr_q               <= lfsr_step(lfsr_q);
      end
      if (cmp_en) begin
        if (diff == '0) score_q <= score_q + 16'd1;
        bit_err_q <= err_sum[32] ? 32'hFFFF_FFFF : err_sum[31:0];
        vcnt_q    <= vcnt_inc;
      end
    end
  end

  assign a1      = ops_q.a1;
  assign a0      = ops_q.a0;
  assign b1      = ops_q.b1;
  assign b0      = ops_q.b0;
  assign score   = score_q;
  assign bit_err = bit_err_q;

endmodule

// File: tb/tb_mul4_fitness_eval.sv
// Directed bench for mul4_fitness_eval: several evaluator instances, each
// paired with a small candidate model (golden, stuck-zero, single-bit fault).
module tb_mul4_fitness_eval;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // _g: golden N=256   _s: y tied 0, N=1   _v: y0[0] inverted, N=16
  // _r: golden N=4     _z: golden N=1, SEED=0
  logic st_g = 1'b0, bz_g, dn_g; logic [15:0] sc_g; logic [31:0] be_g;
  logic [15:0] a1_g, a0_g, b1_g, b0_g, y3_g, y2_g, y1_g, y0_g;
  logic st_s = 1'b0, bz_s, dn_s; logic [15:0] sc_s; logic [31:0] be_s;
  logic [15:0] a1_s, a0_s, b1_s, b0_s;
  logic st_v = 1'b0, bz_v, dn_v; logic [15:0] sc_v; logic [31:0] be_v;
  logic [15:0] a1_v, a0_v, b1_v, b0_v, y3_v, y2_v, y1_v, y0_v;
  logic st_r = 1'b0, bz_r, dn_r; logic [15:0] sc_r; logic [31:0] be_r;
  logic [15:0] a1_r, a0_r, b1_r, b0_r, y3_r, y2_r, y1_r, y0_r;
  logic st_z = 1'b0, bz_z, dn_z; logic [15:0] sc_z; logic [31:0] be_z;
  logic [15:0] a1_z, a0_z, b1_z, b0_z, y3_z, y2_z, y1_z, y0_z;

  assign {y3_g, y2_g, y1_g, y0_g} = 64'({a1_g, a0_g}) * 64'({b1_g, b0_g});
  assign {y3_v, y2_v, y1_v, y0_v} = (64'({a1_v, a0_v}) * 64'({b1_v, b0_v})) ^ 64'd1;
  assign {y3_r, y2_r, y1_r, y0_r} = 64'({a1_r, a0_r}) * 64'({b1_r, b0_r});
  assign {y3_z, y2_z, y1_z, y0_z} = 64'({a1_z, a0_z}) * 64'({b1_z, b0_z});

  mul4_fitness_eval #(.N_VECTORS(256)) u_g (
    .clk(clk), .rst_n(rst_n), .start(st_g), .busy(bz_g), .done(dn_g), .score(sc_g), .bit_err(be_g),
    .a1(a1_g), .a0(a0_g), .b1(b1_g), .b0(b0_g), .y3(y3_g), .y2(y2_g), .y1(y1_g), .y0(y0_g));
  mul4_fitness_eval #(.N_VECTORS(1)) u_s (
    .clk(clk), .rst_n(rst_n), .start(st_s), .busy(bz_s), .done(dn_s), .score(sc_s), .bit_err(be_s),
    .a1(a1_s), .a0(a0_s), .b1(b1_s), .b0(b0_s), .y3(16'h0), .y2(16'h0), .y1(16'h0), .y0(16'h0));
  mul4_fitness_eval #(.N_VECTORS(16)) u_v (
    .clk(clk), .rst_n(rst_n), .start(st_v), .busy(bz_v), .done(dn_v), .score(sc_v), .bit_err(be_v),
    .a1(a1_v), .a0(a0_v), .b1(b1_v), .b0(b0_v), .y3(y3_v), .y2(y2_v), .y1(y1_v), .y0(y0_v));
  mul4_fitness_eval #(.N_VECTORS(4)) u_r (
    .clk(clk), .rst_n(rst_n), .start(st_r), .busy(bz_r), .done(dn_r), .score(sc_r), .bit_err(be_r),
    .a1(a1_r), .a0(a0_r), .b1(b1_r), .b0(b0_r), .y3(y3_r), .y2(y2_r), .y1(y1_r), .y0(y0_r));
  mul4_fitness_eval #(.N_VECTORS(1), .SEED(32'h0)) u_z (
    .clk(clk), .rst_n(rst_n), .start(st_z), .busy(bz_z), .done(dn_z), .score(sc_z), .bit_err(be_z),
    .a1(a1_z), .a0(a0_z), .b1(b1_z), .b0(b0_z), .y3(y3_z), .y2(y2_z), .y1(y1_z), .y0(y0_z));

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if ({bz_g, dn_g, sc_g, be_g, a1_g, a0_g, b1_g, b0_g} !== 114'h0)
      $display("FAIL reset_g: got %h want 0", {bz_g, dn_g, sc_g, be_g, a1_g, a0_g, b1_g, b0_g});
    else n_pass++;
    n_total++;
    if ({bz_z, dn_z, sc_z, be_z, a1_z, a0_z, b1_z, b0_z} !== 114'h0)
      $display("FAIL reset_z: got %h want 0", {bz_z, dn_z, sc_z, be_z, a1_z, a0_z, b1_z, b0_z});
    else n_pass++;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    logic [63:0] p;
    int done_at;
    logic bz_at;
    p = 64'(32'hACE1_2468) * 64'(32'h5670_9234);
    done_at = -1; bz_at = 1'b1;
    @(posedge clk); #1 st_s = 1'b1;
    @(posedge clk); #1 st_s = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        n_total++;
        if ({a1_s, a0_s} !== 32'hACE1_2468) $display("FAIL single_a: got %h want ace12468", {a1_s, a0_s});
        else n_pass++;
      end
      if (k == 2) begin
        n_total++;
        if ({b1_s, b0_s} !== 32'h5670_9234) $display("FAIL single_b: got %h want 56709234", {b1_s, b0_s});
        else n_pass++;
      end
      if (dn_s) begin done_at = k; bz_at = bz_s; break; end
    end
    n_total++;
    if (done_at != 35) $display("FAIL single_done_at: got %0d want 35", done_at); else n_pass++;
    n_total++;
    if (bz_at !== 1'b0) $display("FAIL single_busy_at_done: got %b want 0", bz_at); else n_pass++;
    n_total++;
    if (sc_s !== 16'd0) $display("FAIL single_score: got %0d want 0", sc_s); else n_pass++;
    n_total++;
    if (be_s !== 32'($countones(p))) $display("FAIL single_biterr: got %0d want %0d", be_s, $countones(p));
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (dn_s !== 1'b0) $display("FAIL single_done_width: got %b want 0", dn_s); else n_pass++;
  endtask

  task automatic test_seed0();
    int done_at;
    done_at = -1;
    @(posedge clk); #1 st_z = 1'b1;
    @(posedge clk); #1 st_z = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        n_total++;
        if ({a1_z, a0_z} !== 32'h0000_0001) $display("FAIL seed0_a: got %h want 00000001", {a1_z, a0_z});
        else n_pass++;
      end
      if (k == 2) begin
        n_total++;
        if ({b1_z, b0_z} !== 32'h8020_0003) $display("FAIL seed0_b: got %h want 80200003", {b1_z, b0_z});
        else n_pass++;
      end
      if (dn_z) begin done_at = k; break; end
    end
    n_total++;
    if (done_at != 35 || sc_z !== 16'd1 || be_z !== 32'd0)
      $display("FAIL seed0_result: done_at %0d score %0d biterr %0d want 35 1 0", done_at, sc_z, be_z);
    else n_pass++;
  endtask

  task automatic test_invert();
    int done_at;
    done_at = -1;
    @(posedge clk); #1 st_v = 1'b1;
    @(posedge clk); #1 st_v = 1'b0;
    for (int k = 1; k <= 700; k++) begin
      @(posedge clk); #1;
      if (dn_v) begin done_at = k; break; end
    end
    n_total++;
    if (done_at != 560) $display("FAIL invert_done_at: got %0d want 560", done_at); else n_pass++;
    n_total++;
    if (sc_v !== 16'd0) $display("FAIL invert_score: got %0d want 0", sc_v); else n_pass++;
    n_total++;
    if (be_v !== 32'd16) $display("FAIL invert_biterr: got %0d want 16", be_v); else n_pass++;
  endtask

  task automatic test_start_ignored();
    int done_at, ndone;
    done_at = -1; ndone = 0;
    @(posedge clk); #1 st_r = 1'b1;
    @(posedge clk); #1 st_r = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (dn_r) begin ndone++; if (done_at < 0) done_at = k; end
      if (k == 4 || k == 19) st_r = 1'b1;
      if (k == 5 || k == 20) st_r = 1'b0;
    end
    n_total++;
    if (ndone != 1) $display("FAIL ignored_done_count: got %0d want 1", ndone); else n_pass++;
    n_total++;
    if (done_at != 140) $display("FAIL ignored_done_at: got %0d want 140", done_at); else n_pass++;
    n_total++;
    if (sc_r !== 16'd4 || be_r !== 32'd0) $display("FAIL ignored_result: score %0d biterr %0d want 4 0", sc_r, be_r);
    else n_pass++;
  endtask

  task automatic test_reset_midrun();
    logic [31:0] ra1, rb1, ra2, rb2;
    int ndone;
    ra1 = '0; rb1 = '0; ra2 = '0; rb2 = '0; ndone = 0;
    @(posedge clk); #1 st_r = 1'b1;
    @(posedge clk); #1 st_r = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (k == 1)  ra1 = {a1_r, a0_r};
      if (k == 2)  rb1 = {b1_r, b0_r};
      if (k == 36) ra2 = {a1_r, a0_r};
      if (k == 37) rb2 = {b1_r, b0_r};
    end
    n_total++;
    if (sc_r !== 16'd1 || bz_r !== 1'b1) $display("FAIL midrun_pre: score %0d busy %b want 1 1", sc_r, bz_r);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({bz_r, dn_r, sc_r, be_r, a1_r, a0_r, b1_r, b0_r} !== 114'h0)
      $display("FAIL midrun_reset_outputs: got %h want 0", {bz_r, dn_r, sc_r, be_r, a1_r, a0_r, b1_r, b0_r});
    else n_pass++;
    repeat (5) begin @(posedge clk); #1; if (dn_r) ndone++; end
    rst_n = 1'b1;
    repeat (10) begin @(posedge clk); #1; if (dn_r) ndone++; end
    n_total++;
    if (ndone != 0) $display("FAIL midrun_no_done: got %0d pulses want 0", ndone); else n_pass++;
    @(posedge clk); #1 st_r = 1'b1;
    @(posedge clk); #1 st_r = 1'b0;
    for (int k = 1; k <= 37; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        n_total++;
        if ({a1_r, a0_r} !== ra1 || ra1 !== 32'hACE1_2468)
          $display("FAIL midrun_a1: got %h first run %h want ace12468", {a1_r, a0_r}, ra1);
        else n_pass++;
      end
      if (k == 2) begin
        n_total++;
        if ({b1_r, b0_r} !== rb1) $display("FAIL midrun_b1: got %h want %h", {b1_r, b0_r}, rb1); else n_pass++;
      end
      if (k == 36) begin
        n_total++;
        if ({a1_r, a0_r} !== ra2) $display("FAIL midrun_a2: got %h want %h", {a1_r, a0_r}, ra2); else n_pass++;
      end
      if (k == 37) begin
        n_total++;
        if ({b1_r, b0_r} !== rb2) $display("FAIL midrun_b2: got %h want %h", {b1_r, b0_r}, rb2); else n_pass++;
      end
    end
    // let the restarted run finish so the instance is idle again
    repeat (110) @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int d1, d2;
    d1 = -1; d2 = -1;
    @(posedge clk); #1 st_s = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 73; k++) begin
      @(posedge clk); #1;
      if (dn_s) begin if (d1 < 0) d1 = k; else if (d2 < 0) d2 = k; end
      if (k == 37) begin
        n_total++;
        if (bz_s !== 1'b1) $display("FAIL b2b_restart_busy: got %b want 1", bz_s); else n_pass++;
      end
      if (k == 73) st_s = 1'b0;
    end
    n_total++;
    if (d1 != 35 || d2 != 72) $display("FAIL b2b_done_at: got %0d,%0d want 35,72", d1, d2); else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (bz_s !== 1'b0) $display("FAIL b2b_stop: busy %b want 0", bz_s); else n_pass++;
  endtask

  task automatic test_golden();
    int done_at;
    logic bz_at;
    done_at = -1; bz_at = 1'b1;
    @(posedge clk); #1 st_g = 1'b1;
    @(posedge clk); #1 st_g = 1'b0;
    for (int k = 1; k <= 9100; k++) begin
      @(posedge clk); #1;
      if (dn_g) begin done_at = k; bz_at = bz_g; break; end
    end
    n_total++;
    if (done_at != 8960) $display("FAIL golden_done_at: got %0d want 8960", done_at); else n_pass++;
    n_total++;
    if (sc_g !== 16'd256) $display("FAIL golden_score: got %0d want 256", sc_g); else n_pass++;
    n_total++;
    if (be_g !== 32'd0) $display("FAIL golden_biterr: got %0d want 0", be_g); else n_pass++;
    n_total++;
    if (bz_at !== 1'b0) $display("FAIL golden_busy_at_done: got %b want 0", bz_at); else n_pass++;
    repeat (5) @(posedge clk);
    #1;
    n_total++;
    if (sc_g !== 16'd256 || dn_g !== 1'b0 || bz_g !== 1'b0)
      $display("FAIL golden_hold: score %0d done %b busy %b want 256 0 0", sc_g, dn_g, bz_g);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_seed0();
    test_invert();
    test_start_ignored();
    test_reset_midrun();
    test_back_to_back();
    test_golden();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
